// File: rtl/tft_timing_gen.sv
// TFT/RGB panel timing generator: horizontal/vertical counters, pixel request
// ahead of the active window, and one registered output stage toward the panel.
module tft_timing_gen #(
  parameter int   H_SYNC   = 41,
  parameter int   H_BACK   = 2,
  parameter int   H_VALID  = 480,
  parameter int   H_FRONT  = 2,
  parameter int   V_SYNC   = 10,
  parameter int   V_BACK   = 2,
  parameter int   V_VALID  = 272,
  parameter int   V_FRONT  = 2,
  parameter int   CNT_W    = 12,
  parameter int   DATA_W   = 16,
  parameter int   REQ_LEAD = 1,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_data_vld,
  output logic              pix_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              hsync,
  output logic              vsync,
  output logic              tft_de,
  output logic [DATA_W-1:0] tft_rgb,
  output logic              tft_clk,
  output logic              tft_bl,
  output logic              frame_start,
  output logic              line_start,
  output logic              underrun
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_BEG  = CNT_W'(HA);
  localparam logic [CNT_W-1:0] HA_END  = CNT_W'(HA + H_VALID);
  localparam logic [CNT_W-1:0] VA_BEG  = CNT_W'(VA);
  localparam logic [CNT_W-1:0] VA_END  = CNT_W'(VA + V_VALID);
  localparam logic [CNT_W-1:0] RQ_BEG  = CNT_W'(HA - REQ_LEAD);
  localparam logic [CNT_W-1:0] RQ_END  = CNT_W'(HA + H_VALID - REQ_LEAD);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0] cnt_v_q, cnt_v_d;

  logic              hsync_q, vsync_q, de_q, bl_q, fs_q, ls_q, ur_q;
  logic [DATA_W-1:0] rgb_q;

  logic run, in_rows, req_w, act_w, hs_act, vs_act;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_h_q <= '0;
      cnt_v_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  // Leaving RUN is only possible at the last count, so a frame always completes.
  always_comb begin
    state_d = state_q;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    if (state_q == IDLE) begin
      cnt_h_d = '0;
      cnt_v_d = '0;
      if (en) state_d = RUN;
    end else if (cnt_h_q == H_LAST) begin
      cnt_h_d = '0;
      if (cnt_v_q == V_LAST) begin
        cnt_v_d = '0;
        if (!en) state_d = IDLE;
      end else begin
        cnt_v_d = cnt_v_q + CNT_ONE;
      end
    end else begin
      cnt_h_d = cnt_h_q + CNT_ONE;
    end
  end

  always_comb begin
    run     = (state_q == RUN);
    in_rows = (cnt_v_q >= VA_BEG) && (cnt_v_q < VA_END);
    req_w   = run && in_rows && (cnt_h_q >= RQ_BEG) && (cnt_h_q < RQ_END);
    act_w   = run && in_rows && (cnt_h_q >= HA_BEG) && (cnt_h_q < HA_END);
    hs_act  = run && (cnt_h_q < HS_END);
    vs_act  = run && (cnt_v_q < VS_END);
  end

  assign pix_req = req_w;
  assign pix_x   = req_w ? (cnt_h_q - RQ_BEG) : '1;
  assign pix_y   = req_w ? (cnt_v_q - VA_BEG) : '1;

  // Panel-side stage: every output here lags the counters by one cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      bl_q    <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      hsync_q <= hs_act ? HS_POL : ~HS_POL;
      vsync_q <= vs_act ? VS_POL : ~VS_POL;
      de_q    <= act_w;
      rgb_q   <= (act_w && pix_data_vld) ? pix_data : '0;
      bl_q    <= run;
      fs_q    <= run && (cnt_h_q == '0) && (cnt_v_q == '0);
      ls_q    <= run && (cnt_h_q == '0);
      ur_q    <= ur_q | (act_w & ~pix_data_vld);
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign tft_de      = de_q;
  assign tft_rgb     = rgb_q;
  assign tft_bl      = bl_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign underrun    = ur_q;
  assign tft_clk     = sys_clk;

endmodule
